rf_writeback_unit: RTL and testbench

- Write-side driver for the CPU's 32x32 register file: turns completed load/ALU results into the byte-enabled write port (wen[3:0], waddr, wdata).
- Performs sub-word load alignment and extension (LB/LBU/LH/LHU/LW) and MIPS partial-word merges (LWL/LWR) through byte write enables.
- Keeps a per-register pending-write scoreboard that the decode stage uses for hazard stalls.
- Sits between the MEM stage and the register file write port.

---
 rtl/rf_writeback_unit_pkg.sv | 34 +++
 rtl/rf_writeback_unit_if.sv | 40 ++++
 rtl/rf_writeback_unit_wb_align.sv | 125 ++++++++++++
 rtl/rf_writeback_unit.sv | 150 +++++++++++++++
 tb/tb_rf_writeback_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_writeback_unit_pkg.sv
// ---------------------------------------------------------------------------
// rf_writeback_unit_pkg
// Shared definitions for the register-file writeback unit:
//   - OPW   : width of the writeback op code
//   - NREG  : number of architectural registers
//   - wb_op_e : writeback op encodings (WB_ALU .. WB_LWR)
//   - BE_FULL / BE_NONE : byte-enable constants
//   - be_to_mask() : expands a 4-bit byte enable to a 32-bit bit mask
// ---------------------------------------------------------------------------
package rf_writeback_unit_pkg;

    localparam int OPW  = 3;
    localparam int NREG = 32;

    typedef enum logic [OPW-1:0] {
        WB_ALU = 3'd0,
        WB_LB  = 3'd1,
        WB_LBU = 3'd2,
        WB_LH  = 3'd3,
        WB_LHU = 3'd4,
        WB_LW  = 3'd5,
        WB_LWL = 3'd6,
        WB_LWR = 3'd7
    } wb_op_e;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    // Each enable bit covers one byte lane of the write data.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        be_to_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/rf_writeback_unit_if.sv
// ---------------------------------------------------------------------------
// rf_writeback_unit_if
// Writeback request handshake from the MEM stage into the writeback unit.
//   in_valid : request valid                 (master -> slave)
//   in_ready : unit can accept this cycle    (slave  -> master)
//   in_op    : writeback op code (wb_op_e)   (master -> slave)
//   in_off   : byte offset, addr[1:0]        (master -> slave)
//   in_data  : ALU result or raw memory word (master -> slave)
//   in_rd    : destination register          (master -> slave)
// ---------------------------------------------------------------------------
interface rf_writeback_unit_if
    import rf_writeback_unit_pkg::*;
();

    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [1:0]     in_off;
    logic [31:0]    in_data;
    logic [4:0]     in_rd;

    modport master (
        output in_valid,
        output in_op,
        output in_off,
        output in_data,
        output in_rd,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_off,
        input  in_data,
        input  in_rd,
        output in_ready
    );

endinterface

// File: rtl/rf_writeback_unit_wb_align.sv
// ---------------------------------------------------------------------------
// wb_align
// Purely combinational load alignment / extension and LWL/LWR partial-word
// merge. Produces the byte write enables and the lane-aligned write data.
// Bytes whose enable is clear are driven to zero.
//   op_i    : writeback op code (wb_op_e encoding)
//   off_i   : byte offset of the access
//   data_i  : ALU result or raw memory word
//   wen_o   : byte write enables
//   wdata_o : aligned write data
// ---------------------------------------------------------------------------
module wb_align
    import rf_writeback_unit_pkg::*;
(
    input  logic [OPW-1:0] op_i,
    input  logic [1:0]     off_i,
    input  logic [31:0]    data_i,
    output logic [3:0]     wen_o,
    output logic [31:0]    wdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  wen_s;
    logic [31:0] raw_s;

    // Select the addressed byte and halfword; halfword ignores off[0].
    always_comb begin
        byte_s = 8'h00;
        case (off_i)
            2'd0:    byte_s = data_i[7:0];
            2'd1:    byte_s = data_i[15:8];
            2'd2:    byte_s = data_i[23:16];
            2'd3:    byte_s = data_i[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = off_i[1] ? data_i[31:16] : data_i[15:0];
    end

    // Per-op enables and lane placement.
    always_comb begin
        wen_s = BE_NONE;
        raw_s = 32'h0000_0000;
        case (op_i)
            WB_ALU, WB_LW: begin
                wen_s = BE_FULL;
                raw_s = data_i;
            end
            WB_LB: begin
                wen_s = BE_FULL;
                raw_s = {{24{byte_s[7]}}, byte_s};
            end
            WB_LBU: begin
                wen_s = BE_FULL;
                raw_s = {24'h00_0000, byte_s};
            end
            WB_LH: begin
                wen_s = BE_FULL;
                raw_s = {{16{half_s[15]}}, half_s};
            end
            WB_LHU: begin
                wen_s = BE_FULL;
                raw_s = {16'h0000, half_s};
            end
            // LWL fills the register from the top byte downwards.
            WB_LWL: begin
                case (off_i)
                    2'd0: begin
                        wen_s = 4'h8;
                        raw_s = {data_i[7:0], 24'h00_0000};
                    end
                    2'd1: begin
                        wen_s = 4'hC;
                        raw_s = {data_i[15:0], 16'h0000};
                    end
                    2'd2: begin
                        wen_s = 4'hE;
                        raw_s = {data_i[23:0], 8'h00};
                    end
                    2'd3: begin
                        wen_s = 4'hF;
                        raw_s = data_i;
                    end
                    default: begin
                        wen_s = BE_NONE;
                        raw_s = 32'h0000_0000;
                    end
                endcase
            end
            // LWR fills the register from the bottom byte upwards.
            WB_LWR: begin
                case (off_i)
                    2'd0: begin
                        wen_s = 4'hF;
                        raw_s = data_i;
                    end
                    2'd1: begin
                        wen_s = 4'h7;
                        raw_s = {8'h00, data_i[31:8]};
                    end
                    2'd2: begin
                        wen_s = 4'h3;
                        raw_s = {16'h0000, data_i[31:16]};
                    end
                    2'd3: begin
                        wen_s = 4'h1;
                        raw_s = {24'h00_0000, data_i[31:24]};
                    end
                    default: begin
                        wen_s = BE_NONE;
                        raw_s = 32'h0000_0000;
                    end
                endcase
            end
            default: begin
                wen_s = BE_NONE;
                raw_s = 32'h0000_0000;
            end
        endcase
    end

    assign wen_o   = wen_s;
    assign wdata_o = raw_s & be_to_mask(wen_s);

endmodule

// File: rtl/rf_writeback_unit.sv
// ---------------------------------------------------------------------------
// rf_writeback_unit
// Write-side driver for the 32x32 register file. One registered stage turns
// completed load/ALU results into the byte-enabled write port and keeps a
// per-register pending-write scoreboard for decode hazard detection.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req (slave)       : writeback request handshake (rf_writeback_unit_if)
//   stall             : hold the write stage
//   wen/waddr/wdata   : register file write port (wen gated by retirement)
//   issue_valid/rd    : decode issued an instruction writing issue_rd
//   raddr1/raddr2     : decode read addresses
//   hazard1/hazard2   : read address has a pending write
//   fwd1_hit/fwd2_hit : forward hit on raddr1/raddr2
//   fwd_data          : forwarded value
//
// Optional feature macro WB_FORWARD_EN: when defined, a full-word write
// sitting in the output register is forwarded to decode and suppresses the
// matching hazard. When undefined, forward outputs are tied to zero.
// ---------------------------------------------------------------------------
module rf_writeback_unit
    import rf_writeback_unit_pkg::*;
#(
    parameter int NREG = 32,
    parameter int OPW  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    rf_writeback_unit_if.slave        req,
    input  logic                      stall,
    output logic [3:0]                wen,
    output logic [4:0]                waddr,
    output logic [31:0]               wdata,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic [4:0]                raddr1,
    input  logic [4:0]                raddr2,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic                      fwd1_hit,
    output logic                      fwd2_hit,
    output logic [31:0]               fwd_data
);

    logic [OPW-1:0]  op_s;
    logic [3:0]      al_wen_s;
    logic [31:0]     al_wdata_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            retire_s;
    logic            fwd1_s;
    logic            fwd2_s;

    logic            out_valid_q, out_valid_d;
    logic [3:0]      wen_q,       wen_d;
    logic [4:0]      waddr_q,     waddr_d;
    logic [31:0]     wdata_q,     wdata_d;
    logic [NREG-1:0] busy_q,      busy_d;

    assign op_s = req.in_op;

    wb_align u_wb_align (
        .op_i    (op_s),
        .off_i   (req.in_off),
        .data_i  (req.in_data),
        .wen_o   (al_wen_s),
        .wdata_o (al_wdata_s)
    );

    // The stage can take a new request whenever its content leaves this cycle.
    assign in_ready_s   = ~out_valid_q | ~stall;
    assign req.in_ready = in_ready_s;
    assign accept_s     = req.in_valid & in_ready_s;
    assign retire_s     = out_valid_q & ~stall;

    // Output stage next state: load on accept, drain on retire, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        wen_d       = wen_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            // r0 is hard-wired: the request flows through but never writes.
            wen_d       = (req.in_rd == 5'd0) ? BE_NONE : al_wen_s;
            waddr_d     = req.in_rd;
            wdata_d     = al_wdata_s;
        end else if (retire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Scoreboard next state: clear on retire, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (retire_s) begin
            busy_d[waddr_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Output stage and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            wen_q       <= 4'h0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'h0000_0000;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
        end
    end

`ifdef WB_FORWARD_EN
    // Only full-word writes forward; partial merges need the old value.
    assign fwd1_s   = out_valid_q & (waddr_q == raddr1) & (waddr_q != 5'd0) & (wen_q == BE_FULL);
    assign fwd2_s   = out_valid_q & (waddr_q == raddr2) & (waddr_q != 5'd0) & (wen_q == BE_FULL);
    assign fwd_data = wdata_q;
`else
    assign fwd1_s   = 1'b0;
    assign fwd2_s   = 1'b0;
    assign fwd_data = 32'h0000_0000;
`endif

    assign fwd1_hit = fwd1_s;
    assign fwd2_hit = fwd2_s;
    assign hazard1  = busy_q[raddr1] & ~fwd1_s;
    assign hazard2  = busy_q[raddr2] & ~fwd2_s;

    // The write only reaches the register file in the cycle it retires.
    assign wen   = wen_q & {4{retire_s}};
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
module tb_rf_writeback_unit;
    import rf_writeback_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [3:0]  wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hazard1;
    logic        hazard2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;

    always #5 clk = ~clk;

    rf_writeback_unit_if bus ();

    rf_writeback_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.slave),
        .stall       (stall),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .fwd1_hit    (fwd1_hit),
        .fwd2_hit    (fwd2_hit),
        .fwd_data    (fwd_data)
    );

    typedef struct packed {
        logic [3:0]  wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: what the output stage holds and which regs are busy.
    logic        m_ov    = 1'b0;
    logic [4:0]  m_rd    = 5'd0;
    logic [3:0]  m_wen   = 4'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        busy_m [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-level model of the writeback rules.
    function automatic exp_t model_wb(input int op, input int off, input logic [31:0] d, input logic [4:0] rd);
        logic [7:0]  by [4];
        logic [7:0]  lane [4];
        logic [3:0]  en;
        logic [7:0]  b;
        logic [15:0] h;
        exp_t        r;
        for (int i = 0; i < 4; i++) begin
            by[i]   = d[8*i +: 8];
            lane[i] = 8'h00;
        end
        en     = 4'h0;
        b      = by[off];
        h      = {by[(off/2)*2+1], by[(off/2)*2]};
        r.data = 32'h0;
        case (op)
            0, 5: begin en = 4'hF; r.data = d; end
            1: begin en = 4'hF; r.data = {{24{b[7]}}, b}; end
            2: begin en = 4'hF; r.data = {24'h0, b}; end
            3: begin en = 4'hF; r.data = {{16{h[15]}}, h}; end
            4: begin en = 4'hF; r.data = {16'h0, h}; end
            6: for (int i = 0; i < 4; i++) begin
                   if (i + 3 - off <= 3) begin
                       lane[i + 3 - off] = by[i];
                       en[i + 3 - off]   = 1'b1;
                   end
               end
            default: for (int j = 0; j < 4; j++) begin
                   if (j + off <= 3) begin
                       lane[j] = by[j + off];
                       en[j]   = 1'b1;
                   end
               end
        endcase
        if (op >= 6) r.data = {lane[3], lane[2], lane[1], lane[0]};
        r.wen  = en;
        r.addr = rd;
        return r;
    endfunction

    // Reference model advance on each clock edge; pushes expected writes.
    always @(posedge clk) begin : model
        exp_t e;
        logic acc;
        logic ret;
        if (reset) begin
            m_ov    <= 1'b0;
            m_rd    <= 5'd0;
            m_wen   <= 4'h0;
            m_wdata <= 32'h0;
            for (int i = 0; i < 32; i++) busy_m[i] <= 1'b0;
            exp_q.delete();
        end else begin
            acc = bus.in_valid && (!m_ov || !stall);
            ret = m_ov && !stall;
            if (acc) begin
                e       = model_wb(int'(bus.in_op), int'(bus.in_off), bus.in_data, bus.in_rd);
                m_ov    <= 1'b1;
                m_rd    <= bus.in_rd;
                m_wen   <= (bus.in_rd == 5'd0) ? 4'h0 : e.wen;
                m_wdata <= e.data;
                if (bus.in_rd != 5'd0) exp_q.push_back(e);
            end else if (ret) begin
                m_ov <= 1'b0;
            end
            for (int i = 1; i < 32; i++) begin
                if (issue_valid && issue_rd == i[4:0]) busy_m[i] <= 1'b1;
                else if (ret && m_rd == i[4:0]) busy_m[i] <= 1'b0;
            end
            busy_m[0] <= 1'b0;
        end
    end

    // Monitor: compares DUT outputs with the model on the falling edge.
    initial begin : monitor
        exp_t e;
        logic exp_f1;
        logic exp_f2;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("in_ready", in_ready_w(), (!m_ov || !stall));
            if (wen !== 4'h0) begin
                if (m_ov && !stall && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write", {wen, waddr, wdata}, {e.wen, e.addr, e.data});
                end else begin
                    check("spurious_wen", wen, 4'h0);
                end
            end else if (m_ov && !stall && m_rd != 5'd0) begin
                check("missing_write", wen, m_wen);
                if (exp_q.size() > 0) e = exp_q.pop_front();
            end
`ifdef WB_FORWARD_EN
            exp_f1 = m_ov && (m_rd == raddr1) && (m_rd != 5'd0) && (m_wen == 4'hF);
            exp_f2 = m_ov && (m_rd == raddr2) && (m_rd != 5'd0) && (m_wen == 4'hF);
            if (exp_f1 || exp_f2) check("fwd_data", fwd_data, m_wdata);
`else
            exp_f1 = 1'b0;
            exp_f2 = 1'b0;
            check("fwd_data_off", fwd_data, 32'h0);
`endif
            check("fwd1", fwd1_hit, exp_f1);
            check("fwd2", fwd2_hit, exp_f2);
            check("hazard1", hazard1, busy_m[raddr1] && !exp_f1);
            check("hazard2", hazard2, busy_m[raddr2] && !exp_f2);
        end
    end

    function automatic logic in_ready_w();
        return bus.in_ready;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int op, input int off, input logic [31:0] d, input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_op    = op[2:0];
        bus.in_off   = off[1:0];
        bus.in_data  = d;
        bus.in_rd    = rd;
    endtask

    task automatic dir(input string name, input int op, input int off, input logic [4:0] rd,
                       input logic [3:0] ew, input logic [31:0] ed);
        req(op, off, 32'h8899AABB, rd);
        stall = 1'b0;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({name, "_wen"}, wen, ew);
        check({name, "_wdata"}, wdata, ed);
        step();
    endtask

    initial begin : driver
        reset        = 1'b1;
        stall        = 1'b0;
        issue_valid  = 1'b0;
        issue_rd     = 5'd0;
        raddr1       = 5'd1;
        raddr2       = 5'd2;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd0;
        bus.in_off   = 2'd0;
        bus.in_data  = 32'h0;
        bus.in_rd    = 5'd0;
        step();
        step();
        check("rst_wen", wen, 4'h0);
        check("rst_waddr", waddr, 5'd0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_hazards", {hazard1, hazard2}, 2'b00);
        reset = 1'b0;
        step();

        dir("lb_off1", 1, 1, 5'd1, 4'hF, 32'hFFFFFFAA);
        dir("lhu_off2", 4, 2, 5'd2, 4'hF, 32'h00008899);
        dir("lwl_off1", 6, 1, 5'd3, 4'hC, 32'hAABB0000);
        dir("lwr_off2", 7, 2, 5'd4, 4'h3, 32'h00008899);

        // Every op at every offset, back to back; monitor checks each write.
        for (int op = 0; op < 8; op++) begin
            for (int off = 0; off < 4; off++) begin
                req(op, off, $urandom, 5'((op * 4 + off) % 31 + 1));
                step();
            end
        end
        bus.in_valid = 1'b0;
        step();

        // rd=0 is consumed without writing.
        req(5, 0, 32'hDEADBEEF, 5'd0);
        raddr1 = 5'd0;
        @(negedge clk);
        check("rd0_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rd0_wen", wen, 4'h0);
        check("rd0_hazard", hazard1, 1'b0);
        step();

        // Stall for three cycles with an LW to r5 in the output stage.
        req(5, 0, 32'h12345678, 5'd5);
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        step();
        req(5, 0, 32'h0BADF00D, 5'd6);
        issue_valid = 1'b0;
        stall       = 1'b1;
        raddr1      = 5'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_wen", wen, 4'h0);
            check("stall_ready", bus.in_ready, 1'b0);
            check("stall_waddr", waddr, 5'd5);
            step();
        end
        stall        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("release_wen", wen, 4'hF);
        check("release_data", {waddr, wdata}, {5'd5, 32'h12345678});
        step();
        @(negedge clk);
        check("release_once", wen, 4'h0);

        // Re-issue of r7 in the same cycle its write retires keeps it busy.
        req(5, 0, 32'h77777777, 5'd7);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        bus.in_valid = 1'b0;
        raddr1       = 5'd7;
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        check("set_wins_hazard1", hazard1, 1'b1);
        step();

        // Reset in the middle of a stall.
        req(5, 0, 32'h99999999, 5'd9);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        bus.in_valid = 1'b0;
        issue_valid  = 1'b0;
        stall        = 1'b1;
        raddr1       = 5'd9;
        raddr2       = 5'd7;
        @(negedge clk);
        check("midstall_wen", wen, 4'h0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("mrst_wen", wen, 4'h0);
        check("mrst_hazards", {hazard1, hazard2}, 2'b00);
        check("mrst_ready", bus.in_ready, 1'b1);
        step();
        reset = 1'b0;
        stall = 1'b0;
        step();

`ifdef WB_FORWARD_EN
        req(5, 0, 32'h8899AABB, 5'd3);
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        step();
        bus.in_valid = 1'b0;
        issue_valid  = 1'b0;
        stall        = 1'b1;
        raddr2       = 5'd3;
        @(negedge clk);
        check("fwd_lw_hit", fwd2_hit, 1'b1);
        check("fwd_lw_hazard", hazard2, 1'b0);
        check("fwd_lw_data", fwd_data, 32'h8899AABB);
        step();
        stall = 1'b0;
        req(6, 1, 32'h8899AABB, 5'd3);
        issue_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        issue_valid  = 1'b0;
        stall        = 1'b1;
        @(negedge clk);
        check("fwd_lwl_hit", fwd2_hit, 1'b0);
        check("fwd_lwl_hazard", hazard2, 1'b1);
        step();
        stall = 1'b0;
        step();
`endif

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            bus.in_valid = 1'($urandom % 2);
            bus.in_op    = 3'($urandom % 8);
            bus.in_off   = 2'($urandom % 4);
            bus.in_data  = $urandom;
            bus.in_rd    = 5'($urandom % 8);
            stall        = ($urandom % 4) == 0;
            issue_valid  = 1'($urandom % 2);
            issue_rd     = 5'($urandom % 8);
            raddr1       = 5'($urandom % 8);
            raddr2       = 5'($urandom % 8);
            step();
        end

        bus.in_valid = 1'b0;
        issue_valid  = 1'b0;
        stall        = 1'b0;
        repeat (4) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
